// File: rtl/divider_arbiter.sv
// divider_arbiter: round-robin share of one pipelined signed divider, result DIV_LATENCY+2 cycles after accept.
// Results cannot stall; grants stop only while the tag FIFO is full. DIVIDER_ARBITER_DIVZERO_EN flags x/0 results.

module sync_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_vld,
   input  logic [W-1:0]               push_dat,
   input  logic                       pop_vld,
   output logic [W-1:0]               head_dat,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push_vld & ~full;
   assign do_pop   = pop_vld & ~empty;
   assign head_dat = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_dat;
   end
endmodule

module divider_arbiter #(
   parameter int WIDTH       = 32,
   parameter int NUM_REQ     = 4,
   parameter int DIV_LATENCY = 16,
   parameter int ID_W        = 2
) (
   input  logic                                clk_in,
   input  logic                                rst_in,
   input  logic [NUM_REQ-1:0]                  req_valid_in,
   input  logic [NUM_REQ*WIDTH-1:0]            req_dividend_in,
   input  logic [NUM_REQ*WIDTH-1:0]            req_divisor_in,
   output logic [NUM_REQ-1:0]                  req_ready_out,
   output logic [WIDTH-1:0]                    div_dividend_out,
   output logic [WIDTH-1:0]                    div_divisor_out,
   output logic                                div_valid_out,
   input  logic [WIDTH-1:0]                    div_quotient_in,
   input  logic [WIDTH-1:0]                    div_remainder_in,
   input  logic                                div_valid_in,
   output logic                                res_valid_out,
   output logic [ID_W-1:0]                     res_id_out,
   output logic [WIDTH-1:0]                    res_quotient_out,
   output logic [WIDTH-1:0]                    res_remainder_out,
   output logic                                res_divzero_out,
   output logic [$clog2(DIV_LATENCY+3)-1:0]    inflight_out,
   output logic                                protocol_err_out
);
   localparam int DEPTH = DIV_LATENCY + 2;
`ifdef DIVIDER_ARBITER_DIVZERO_EN
   localparam int TAG_W = ID_W + 1;
`else
   localparam int TAG_W = ID_W;
`endif
   localparam logic [ID_W:0]   NREQ = (ID_W+1)'(NUM_REQ);
   localparam logic [ID_W-1:0] LAST = ID_W'(NUM_REQ-1);

   logic [WIDTH-1:0] dividend [NUM_REQ];
   logic [WIDTH-1:0] divisor  [NUM_REQ];
   logic [ID_W-1:0]  ptr;
   logic [ID_W-1:0]  gnt_idx;
   logic [ID_W:0]    scan;
   logic             found;
   logic             accept;
   logic             pop;
   logic             full;
   logic             empty;
   logic [TAG_W-1:0] push_tag;
   logic [TAG_W-1:0] head_tag;

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         dividend[i] = req_dividend_in[i*WIDTH +: WIDTH];
         divisor[i]  = req_divisor_in[i*WIDTH +: WIDTH];
      end
   end

   // Round-robin scan starting at ptr; scan is one bit wider so the wrap works for any NUM_REQ.
   always_comb begin
      found   = 1'b0;
      gnt_idx = '0;
      scan    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan = {1'b0, ptr} + (ID_W+1)'(k);
         if (scan >= NREQ) scan = scan - NREQ;
         if (!found && req_valid_in[scan[ID_W-1:0]]) begin
            found   = 1'b1;
            gnt_idx = scan[ID_W-1:0];
         end
      end
   end

   assign accept        = found & ~full & ~rst_in;
   assign req_ready_out = accept ? (NUM_REQ'(1) << gnt_idx) : '0;
   assign pop           = div_valid_in & ~empty;

`ifdef DIVIDER_ARBITER_DIVZERO_EN
   assign push_tag = {(divisor[gnt_idx] == '0), gnt_idx};
`else
   assign push_tag = gnt_idx;
`endif

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         ptr              <= '0;
         div_valid_out    <= 1'b0;
         div_dividend_out <= '0;
         div_divisor_out  <= '0;
      end else begin
         div_valid_out <= accept;
         if (accept) begin
            ptr              <= (gnt_idx == LAST) ? '0 : gnt_idx + ID_W'(1);
            div_dividend_out <= dividend[gnt_idx];
            div_divisor_out  <= divisor[gnt_idx];
         end
      end
   end

   sync_fifo #(.W(TAG_W), .DEPTH(DEPTH)) u_tag_fifo (
      .clk      (clk_in),
      .rst      (rst_in),
      .push_vld (accept),
      .push_dat (push_tag),
      .pop_vld  (pop),
      .head_dat (head_tag),
      .count    (inflight_out),
      .full     (full),
      .empty    (empty)
   );

   // A divider valid with no tag is a stale result (e.g. after reset) and is dropped.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         res_valid_out     <= 1'b0;
         res_id_out        <= '0;
         res_quotient_out  <= '0;
         res_remainder_out <= '0;
         protocol_err_out  <= 1'b0;
      end else begin
         res_valid_out    <= pop;
         protocol_err_out <= div_valid_in & empty;
         if (pop) begin
            res_id_out <= head_tag[ID_W-1:0];
`ifdef DIVIDER_ARBITER_DIVZERO_EN
            res_quotient_out  <= head_tag[ID_W] ? '1 : div_quotient_in;
            res_remainder_out <= head_tag[ID_W] ? '0 : div_remainder_in;
`else
            res_quotient_out  <= div_quotient_in;
            res_remainder_out <= div_remainder_in;
`endif
         end
      end
   end

`ifdef DIVIDER_ARBITER_DIVZERO_EN
   always_ff @(posedge clk_in) begin
      if (rst_in)   res_divzero_out <= 1'b0;
      else if (pop) res_divzero_out <= head_tag[ID_W];
   end
`else
   assign res_divzero_out = 1'b0;
`endif
endmodule

// File: tb/tb_divider_arbiter.sv
// Randomised bench for divider_arbiter with a latency-accurate divider stub and a queue-based reference model.
module tb_divider_arbiter;
   localparam int WIDTH   = 32;
   localparam int NUM_REQ = 4;
   localparam int LAT     = 16;
   localparam int ID_W    = 2;
   localparam int DEPTH   = LAT + 2;

   logic                            clk_in = 1'b0;
   logic                            rst_in;
   logic [NUM_REQ-1:0]              req_valid_in;
   logic [NUM_REQ-1:0][WIDTH-1:0]   dvd_p;
   logic [NUM_REQ-1:0][WIDTH-1:0]   dvs_p;
   logic [NUM_REQ-1:0]              req_ready_out;
   logic [WIDTH-1:0]                div_dividend_out;
   logic [WIDTH-1:0]                div_divisor_out;
   logic                            div_valid_out;
   logic [WIDTH-1:0]                div_quotient_in  = '0;
   logic [WIDTH-1:0]                div_remainder_in = '0;
   logic                            div_valid_in     = 1'b0;
   logic                            res_valid_out;
   logic [ID_W-1:0]                 res_id_out;
   logic [WIDTH-1:0]                res_quotient_out;
   logic [WIDTH-1:0]                res_remainder_out;
   logic                            res_divzero_out;
   logic [$clog2(LAT+3)-1:0]        inflight_out;
   logic                            protocol_err_out;

   always #5 clk_in = ~clk_in;

   divider_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .DIV_LATENCY(LAT), .ID_W(ID_W)) dut (
      .clk_in            (clk_in),
      .rst_in            (rst_in),
      .req_valid_in      (req_valid_in),
      .req_dividend_in   (dvd_p),
      .req_divisor_in    (dvs_p),
      .req_ready_out     (req_ready_out),
      .div_dividend_out  (div_dividend_out),
      .div_divisor_out   (div_divisor_out),
      .div_valid_out     (div_valid_out),
      .div_quotient_in   (div_quotient_in),
      .div_remainder_in  (div_remainder_in),
      .div_valid_in      (div_valid_in),
      .res_valid_out     (res_valid_out),
      .res_id_out        (res_id_out),
      .res_quotient_out  (res_quotient_out),
      .res_remainder_out (res_remainder_out),
      .res_divzero_out   (res_divzero_out),
      .inflight_out      (inflight_out),
      .protocol_err_out  (protocol_err_out)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   function automatic int iabs(input int x);
      return (x < 0) ? -x : x;
   endfunction

   // ---------------- divider stub: fixed latency, never reset, can be held for tests
   typedef struct { int a; int b; int due; } stub_t;
   stub_t sq[$];
   stub_t st_e;
   int    cyc  = 0;
   logic  hold = 1'b0;

   initial forever begin
      @(posedge clk_in);
      if (div_valid_in) sq.delete(0);
      if (div_valid_out === 1'b1) begin
         st_e.a   = $signed(div_dividend_out);
         st_e.b   = $signed(div_divisor_out);
         st_e.due = cyc + LAT;
         sq.push_back(st_e);
      end
      cyc++;
      #2;
      if (!hold && sq.size() > 0 && sq[0].due <= cyc) begin
         div_valid_in = 1'b1;
         if (sq[0].b == 0) begin
            div_quotient_in  = '0;
            div_remainder_in = '0;
         end else begin
            div_quotient_in  = sq[0].a / sq[0].b;
            div_remainder_in = iabs(sq[0].a) % iabs(sq[0].b);
         end
      end else begin
         div_valid_in = 1'b0;
      end
   end

   // ---------------- reference model: queue of issued operations in order
   typedef struct { int id; int a; int b; } op_t;
   op_t   mq[$];
   op_t   m_op;
   int    m_ptr = 0;
   int    m_idx;
   int    gi;
   logic [NUM_REQ-1:0] exp_rdy;
   int    e_div_vld = 0, e_div_a = 0, e_div_b = 0;
   int    e_res_vld = 0, e_res_id = 0, e_res_q = 0, e_res_r = 0, e_res_dz = 0, e_err = 0;
   logic  mon_on = 1'b0;

   int acc_id[$], acc_cyc[$], res_id[$], res_cyc[$], res_qv[$], res_rv[$], res_dzv[$];
   int err_cnt = 0;

   initial forever begin
      @(negedge clk_in);
      if (mon_on) begin
         check("div_valid", 32'(div_valid_out), e_div_vld);
         check("div_dividend", div_dividend_out, e_div_a);
         check("div_divisor", div_divisor_out, e_div_b);
         check("res_valid", 32'(res_valid_out), e_res_vld);
         check("protocol_err", 32'(protocol_err_out), e_err);
         check("inflight", 32'(inflight_out), mq.size());
         if (e_res_vld != 0) begin
            check("res_id", 32'(res_id_out), e_res_id);
            check("res_quotient", res_quotient_out, e_res_q);
            check("res_remainder", res_remainder_out, e_res_r);
            check("res_divzero", 32'(res_divzero_out), e_res_dz);
         end
         if (res_valid_out === 1'b1) begin
            res_id.push_back(int'(res_id_out));
            res_cyc.push_back(cyc);
            res_qv.push_back($signed(res_quotient_out));
            res_rv.push_back($signed(res_remainder_out));
            res_dzv.push_back(int'(res_divzero_out));
         end
         if (protocol_err_out === 1'b1) err_cnt++;

         exp_rdy = '0;
         gi = -1;
         if (!rst_in && mq.size() < DEPTH) begin
            for (int k = 0; k < NUM_REQ; k++) begin
               m_idx = (m_ptr + k) % NUM_REQ;
               if (gi < 0 && req_valid_in[m_idx[ID_W-1:0]]) gi = m_idx;
            end
         end
         if (gi >= 0) exp_rdy[gi[ID_W-1:0]] = 1'b1;
         check("req_ready", 32'(req_ready_out), 32'(exp_rdy));

         if (rst_in) begin
            mq.delete();
            m_ptr = 0;
            e_div_vld = 0; e_div_a = 0; e_div_b = 0;
            e_res_vld = 0; e_res_id = 0; e_res_q = 0; e_res_r = 0; e_res_dz = 0; e_err = 0;
         end else begin
            e_res_vld = 0;
            e_err     = 0;
            if (div_valid_in) begin
               if (mq.size() > 0) begin
                  m_op      = mq.pop_front();
                  e_res_vld = 1;
                  e_res_id  = m_op.id;
`ifdef DIVIDER_ARBITER_DIVZERO_EN
                  e_res_dz  = (m_op.b == 0) ? 1 : 0;
`else
                  e_res_dz  = 0;
`endif
                  if (e_res_dz != 0) begin
                     e_res_q = -1;
                     e_res_r = 0;
                  end else begin
                     e_res_q = m_op.a / m_op.b;
                     e_res_r = iabs(m_op.a) % iabs(m_op.b);
                  end
               end else begin
                  e_err = 1;
               end
            end
            e_div_vld = 0;
            if (gi >= 0) begin
               m_op.id   = gi;
               m_op.a    = $signed(dvd_p[gi[ID_W-1:0]]);
               m_op.b    = $signed(dvs_p[gi[ID_W-1:0]]);
               mq.push_back(m_op);
               e_div_vld = 1;
               e_div_a   = m_op.a;
               e_div_b   = m_op.b;
               m_ptr     = (gi + 1) % NUM_REQ;
               acc_id.push_back(gi);
               acc_cyc.push_back(cyc);
            end
         end
      end
   end

   // ---------------- stimulus helpers
   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic set_op(input int i, input int a, input int b);
      dvd_p[i[ID_W-1:0]] = a;
      dvs_p[i[ID_W-1:0]] = b;
   endtask

   task automatic clear_logs();
      acc_id.delete(); acc_cyc.delete(); res_id.delete(); res_cyc.delete();
      res_qv.delete(); res_rv.delete(); res_dzv.delete();
      err_cnt = 0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 300; i++) begin
         if (mq.size() == 0 && sq.size() == 0) begin
            step();
            step();
            return;
         end
         step();
      end
      check("idle_timeout", 32'(mq.size() + sq.size()), 0);
   endtask

   task automatic wait_res(input int n, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (res_id.size() >= n) return;
         step();
      end
      check("res_timeout", 32'(res_id.size()), n);
   endtask

   task automatic do_reset();
      rst_in = 1'b1;
      step();
      step();
      rst_in = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int b;
      rst_in       = 1'b1;
      req_valid_in = '0;
      dvd_p        = '0;
      dvs_p        = '0;
      @(posedge clk_in);
      #1;
      mon_on = 1'b1;
      step();
      check("rst_ready", 32'(req_ready_out), 0);
      check("rst_inflight", 32'(inflight_out), 0);
      check("rst_div_valid", 32'(div_valid_out), 0);
      check("rst_res_valid", 32'(res_valid_out), 0);
      req_valid_in = 4'hF;
      set_op(0, 5, 1);
      #2;
      check("rst_ready_held", 32'(req_ready_out), 0);
      req_valid_in = '0;
      step();
      rst_in = 1'b0;
      step();

      // single request 100/7 from requester 1
      clear_logs();
      set_op(1, 100, 7);
      req_valid_in = 4'b0010;
      step();
      req_valid_in = '0;
      wait_res(1, 40);
      step();
      if (res_id.size() >= 1 && acc_id.size() >= 1) begin
         check("a_acc_id", acc_id[0], 1);
         check("a_res_id", res_id[0], 1);
         check("a_quotient", res_qv[0], 14);
         check("a_remainder", res_rv[0], 2);
         check("a_latency", res_cyc[0] - acc_cyc[0], 18);
      end
      check("a_inflight", 32'(inflight_out), 0);

      // all four valid for 8 cycles right after reset
      wait_idle();
      do_reset();
      clear_logs();
      for (int i = 0; i < NUM_REQ; i++) set_op(i, 1000 * (i + 1), i + 3);
      req_valid_in = 4'hF;
      repeat (8) step();
      req_valid_in = '0;
      wait_res(8, 60);
      step();
      if (acc_id.size() >= 8 && res_id.size() >= 8) begin
         for (int i = 0; i < 8; i++) begin
            check($sformatf("b_grant%0d", i), acc_id[i], i % 4);
            check($sformatf("b_result%0d", i), res_id[i], i % 4);
            if (i > 0) check($sformatf("b_gap%0d", i), res_cyc[i] - res_cyc[i-1], 1);
         end
      end

      // signed operand combinations
      wait_idle();
      clear_logs();
      req_valid_in = 4'b0001;
      set_op(0, -100, 7);
      step();
      set_op(0, 100, -7);
      step();
      set_op(0, -100, -7);
      step();
      req_valid_in = '0;
      wait_res(3, 40);
      if (res_qv.size() >= 3) begin
         check("c_q_neg_pos", res_qv[0], -14);
         check("c_r_neg_pos", res_rv[0], 2);
         check("c_q_pos_neg", res_qv[1], -14);
         check("c_q_neg_neg", res_qv[2], 14);
      end

      // tag FIFO full: divider results held back
      wait_idle();
      clear_logs();
      hold = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) set_op(i, 77 + i, 5);
      req_valid_in = 4'hF;
      repeat (22) step();
      check("d_ready_zero", 32'(req_ready_out), 0);
      check("d_inflight_full", 32'(inflight_out), 18);
      check("d_acc_count", 32'(acc_id.size()), 18);
      hold = 1'b0;
      #2;
      check("d_ready_release_cycle", 32'(req_ready_out), 0);
      step();
      check("d_ready_back", 32'(req_ready_out != '0), 1);
      step();
      req_valid_in = '0;
      wait_idle();

      // reset with operations still inside the divider
      clear_logs();
      for (int i = 0; i < NUM_REQ; i++) set_op(i, 500 - i, 9);
      req_valid_in = 4'hF;
      repeat (5) step();
      req_valid_in = '0;
      step();
      step();
      rst_in = 1'b1;
      step();
      rst_in = 1'b0;
      repeat (30) step();
      check("e_acc_count", 32'(acc_id.size()), 5);
      check("e_err_pulses", err_cnt, 5);
      check("e_no_results", 32'(res_id.size()), 0);
      check("e_inflight", 32'(inflight_out), 0);

`ifdef DIVIDER_ARBITER_DIVZERO_EN
      wait_idle();
      clear_logs();
      req_valid_in = 4'b0100;
      set_op(2, 55, 0);
      step();
      set_op(2, 9, 3);
      step();
      req_valid_in = '0;
      wait_res(2, 40);
      if (res_qv.size() >= 2) begin
         check("f_id", res_id[0], 2);
         check("f_divzero", res_dzv[0], 1);
         check("f_q_forced", res_qv[0], -1);
         check("f_r_forced", res_rv[0], 0);
         check("f_q_next", res_qv[1], 3);
         check("f_divzero_next", res_dzv[1], 0);
      end
`endif

      // randomised traffic with occasional divider stalls
      wait_idle();
      for (int n = 0; n < 400; n++) begin
         req_valid_in = NUM_REQ'($urandom_range(0, 15));
         for (int i = 0; i < NUM_REQ; i++) begin
            b = int'($urandom_range(0, 200)) - 100;
`ifndef DIVIDER_ARBITER_DIVZERO_EN
            if (b == 0) b = 1;
`endif
            set_op(i, int'($urandom_range(0, 2000)) - 1000, b);
         end
         hold = ($urandom_range(0, 7) == 0);
         step();
      end
      req_valid_in = '0;
      hold = 1'b0;
      wait_idle();
      check("g_inflight_end", 32'(inflight_out), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
